// File: rtl/sbqm_pkg.sv
// ----------------------------------------------------------------------------
// sbqm_pkg
// Shared types and elaboration-time helpers for the smart bank queue manager.
//   state_e    : divider FSM states (ST_LOAD, ST_DIV, ST_STORE)
//   waitWidth  : width of a wait-time result (count width + service width)
//   maxCount   : largest occupancy a queue counter can hold
//   ptrWidth   : bits needed to index n items (minimum 1)
// Optional feature macro used elsewhere in this slice: SBQM_DEBOUNCE_EN.
// ----------------------------------------------------------------------------
package sbqm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DIV   = 2'd1,
        ST_STORE = 2'd2
    } state_e;

    function automatic int waitWidth(input int cntW, input int svcW);
        return cntW + svcW;
    endfunction

    function automatic int maxCount(input int cntW);
        return (1 << cntW) - 1;
    endfunction

    function automatic int ptrWidth(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sbqm_edge_det.sv
// ----------------------------------------------------------------------------
// sbqm_edge_det
// Turns one asynchronous photo-sensor level into a registered one-cycle pulse
// per rising edge. Two-flop synchroniser, optional debounce filter, then a
// rising-edge detector.
// Configuration macro: SBQM_DEBOUNCE_EN
//   defined     : the synced level must hold a new value for DB_CYC
//                 consecutive cycles before the filtered level follows it.
//   not defined : any synced rising edge produces a pulse.
// Ports
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   sig_i   in   raw sensor level (asynchronous)
//   pulse_o out  one-cycle pulse per accepted rising edge
// ----------------------------------------------------------------------------
module sbqm_edge_det
`ifdef SBQM_DEBOUNCE_EN
#(
    parameter int DB_CYC = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic levelPrev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef SBQM_DEBOUNCE_EN
    import sbqm_pkg::*;

    localparam int DBC_W = ptrWidth(DB_CYC);

    logic [DBC_W-1:0] dbCnt_q;
    logic             filt_q;

    // The stability counter restarts whenever the synced level agrees with
    // the filtered one, so only an uninterrupted run of DB_CYC cycles at the
    // new level is able to move the filtered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q  <= 1'b0;
            dbCnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            dbCnt_q <= '0;
        end else if (dbCnt_q == DBC_W'(DB_CYC - 1)) begin
            filt_q  <= sync2_q;
            dbCnt_q <= '0;
        end else begin
            dbCnt_q <= dbCnt_q + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            levelPrev_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            levelPrev_q <= level;
            pulse_q     <= level & ~levelPrev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sbqm_multi_queue.sv
// ----------------------------------------------------------------------------
// sbqm_multi_queue
// N_CH independent customer queues counted from entry/exit photo sensors,
// with full/empty and sticky overflow/underflow flags, plus a shared
// round-robin restoring divider producing wait = count*SVC_T/tellers.
// Configuration macro: SBQM_DEBOUNCE_EN (adds DB_CYC debounce to every sensor).
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   ent_i        in   N_CH entry sensors (asynchronous levels)
//   ext_i        in   N_CH exit sensors (asynchronous levels)
//   tellers_i    in   number of active tellers (shared divisor)
//   clr_flags_i  in   clears ovf_o/unf_o
//   count_o      out  per-queue occupancy, ch0 in LSBs
//   full_o       out  count == MAX
//   empty_o      out  count == 0
//   ovf_o        out  sticky: entry seen while full
//   unf_o        out  sticky: exit seen while empty
//   wait_o       out  per-queue estimated wait, ch0 in LSBs
//   wait_vld_o   out  wait_o[ch] written at least once since reset
// ----------------------------------------------------------------------------
module sbqm_multi_queue
    import sbqm_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 3,
    parameter int SVC_W  = 4,
    parameter int SVC_T  = 5,
    parameter int TELL_W = 2
`ifdef SBQM_DEBOUNCE_EN
    ,
    parameter int DB_CYC = 4
`endif
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CH-1:0]                ent_i,
    input  logic [N_CH-1:0]                ext_i,
    input  logic [TELL_W-1:0]              tellers_i,
    input  logic                           clr_flags_i,
    output logic [N_CH*CNT_W-1:0]          count_o,
    output logic [N_CH-1:0]                full_o,
    output logic [N_CH-1:0]                empty_o,
    output logic [N_CH-1:0]                ovf_o,
    output logic [N_CH-1:0]                unf_o,
    output logic [N_CH*(CNT_W+SVC_W)-1:0]  wait_o,
    output logic [N_CH-1:0]                wait_vld_o
);

    localparam int WAIT_W = waitWidth(CNT_W, SVC_W);
    localparam int PTR_W  = ptrWidth(N_CH);
    localparam int BIT_W  = ptrWidth(WAIT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(maxCount(CNT_W));

    logic [N_CH-1:0]   entPulse;
    logic [N_CH-1:0]   extPulse;

    logic [CNT_W-1:0]  count_q [N_CH];
    logic [CNT_W-1:0]  count_d [N_CH];
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [N_CH-1:0]   unf_q, unf_d;

    state_e            state_q;
    logic [PTR_W-1:0]  chPtr_q;
    logic [TELL_W-1:0] divisor_q;
    logic [TELL_W-1:0] rem_q;
    logic [WAIT_W-1:0] quo_q;
    logic [BIT_W-1:0]  bitCnt_q;
    logic [WAIT_W-1:0] wait_q [N_CH];
    logic [N_CH-1:0]   waitVld_q;

    logic [WAIT_W-1:0] product;
    logic [TELL_W:0]   remShift;
    logic [TELL_W-1:0] remSub;
    logic              remFits;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_sensor
`ifdef SBQM_DEBOUNCE_EN
        sbqm_edge_det #(.DB_CYC(DB_CYC)) u_ent (
            .clk(clk), .rst(rst), .sig_i(ent_i[ch]), .pulse_o(entPulse[ch])
        );
        sbqm_edge_det #(.DB_CYC(DB_CYC)) u_ext (
            .clk(clk), .rst(rst), .sig_i(ext_i[ch]), .pulse_o(extPulse[ch])
        );
`else
        sbqm_edge_det u_ent (
            .clk(clk), .rst(rst), .sig_i(ent_i[ch]), .pulse_o(entPulse[ch])
        );
        sbqm_edge_det u_ext (
            .clk(clk), .rst(rst), .sig_i(ext_i[ch]), .pulse_o(extPulse[ch])
        );
`endif
    end

    // Saturating occupancy counters. An entry and exit in the same cycle
    // cancel. A flag event wins over clr_flags_i because the set is applied
    // after the clear.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            count_d[ch] = count_q[ch];
            ovf_d[ch]   = ovf_q[ch] & ~clr_flags_i;
            unf_d[ch]   = unf_q[ch] & ~clr_flags_i;
            if (entPulse[ch] && !extPulse[ch]) begin
                if (count_q[ch] != CNT_MAX) begin
                    count_d[ch] = count_q[ch] + 1'b1;
                end else begin
                    ovf_d[ch] = 1'b1;
                end
            end else if (extPulse[ch] && !entPulse[ch]) begin
                if (count_q[ch] != '0) begin
                    count_d[ch] = count_q[ch] - 1'b1;
                end else begin
                    unf_d[ch] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                count_q[ch] <= '0;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Restoring-divide datapath. The remainder is always below the divisor,
    // so after the shift it fits in TELL_W+1 bits; when the subtraction is
    // taken its result fits back in TELL_W bits, letting the low bits alone
    // be subtracted.
    always_comb begin
        product  = WAIT_W'(count_q[chPtr_q]) * WAIT_W'(SVC_T);
        remShift = {rem_q, quo_q[WAIT_W-1]};
        remFits  = (remShift >= {1'b0, divisor_q});
        remSub   = remShift[TELL_W-1:0] - divisor_q;
    end

    // Round-robin divider FSM. quo_q starts as the dividend and shifts left
    // one bit per DIV cycle while quotient bits enter at the bottom, so after
    // WAIT_W cycles it holds the quotient. A zero divisor bypasses DIV and
    // stores the all-ones saturation value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            chPtr_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bitCnt_q  <= '0;
            waitVld_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                wait_q[ch] <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    divisor_q <= tellers_i;
                    rem_q     <= '0;
                    bitCnt_q  <= '0;
                    if (tellers_i == '0) begin
                        quo_q   <= '1;
                        state_q <= ST_STORE;
                    end else begin
                        quo_q   <= product;
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (remFits) begin
                        rem_q <= remSub;
                        quo_q <= {quo_q[WAIT_W-2:0], 1'b1};
                    end else begin
                        rem_q <= remShift[TELL_W-1:0];
                        quo_q <= {quo_q[WAIT_W-2:0], 1'b0};
                    end
                    bitCnt_q <= bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_W'(WAIT_W - 1)) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    wait_q[chPtr_q]    <= quo_q;
                    waitVld_q[chPtr_q] <= 1'b1;
                    if (chPtr_q == PTR_W'(N_CH - 1)) begin
                        chPtr_q <= '0;
                    end else begin
                        chPtr_q <= chPtr_q + 1'b1;
                    end
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_out
        assign count_o[ch*CNT_W +: CNT_W]   = count_q[ch];
        assign full_o[ch]                   = (count_q[ch] == CNT_MAX);
        assign empty_o[ch]                  = (count_q[ch] == '0);
        assign wait_o[ch*WAIT_W +: WAIT_W]  = wait_q[ch];
    end

    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign wait_vld_o = waitVld_q;

endmodule
